seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised serial sequence detector. It watches a one-bit input stream and raises a Mealy match output when the last N sampled bits equal a runtime-programmable pattern. The pattern is loaded at reset from a parameter and can be changed in-band. Overlapping and non-overlapping detection are selectable at run time, and an optional saturating match counter can be compiled in. It is the generalised successor of the fixed 4-bit pattern detectors in the serial-input FSM group.

## Interface
- N, 4: pattern length in bits; legal range 2..16.
- DEFAULT_PAT, 4'b1101: pattern after reset, N bits wide.
- CW, 8: match counter width; legal range 1..16.

- CLK  input  1  single clock; all state updates on posedge.
- RST  input  1  reset; synchronous, active-high.
- E  input  1  serial data bit.
- EN  input  1  sample strobe; E is consumed only in cycles with EN=1.
- LOAD  input  1  pattern load strobe.
- PAT  input  N  new pattern, captured when LOAD=1. PAT[N-1] is the first bit expected; PAT[0] is the last.
- OVL  input  1  1 = overlapping detection, 0 = non-overlapping.
- Y  output  1  match indicator (Mealy, combinational).
- CNT  output  CW  saturating count of matches.

## Operation
- State:
  - pat_r: N bits.
  - hist: N-1 bits, holding previously sampled bits, newest in bit 0.
  - fill: bits seen since the last clear, saturating at N-1.
  - cnt: CW bits.
- Reset (RST=1 at posedge):
  - pat_r=DEFAULT_PAT, hist=0, fill=0, cnt=0.
  - RST has priority over LOAD and EN.
- Match term: hit = EN & ~LOAD & (fill == N-1) & ({hist, E} == pat_r).
- Output: Y = hit.
- LOAD=1 (no RST):
  - pat_r<=PAT, hist<=0, fill<=0.
  - The sample in that cycle is discarded, even if EN=1.
- EN=1, LOAD=0, hit=0:
  - hist<={hist[N-3:0], E}. For N=2, hist<=E.
  - fill<=min(fill+1, N-1).
- EN=1, LOAD=0, hit=1, OVL=1: same update as hit=0, so the matching bits can start the next match.
- EN=1, LOAD=0, hit=1, OVL=0:
  - hist<=0, fill<=0.
  - The next match needs N fresh bits.
- EN=0: state holds and Y=0.
- Counter:
  - When hit=1, cnt<=cnt+1, saturating at 2^CW-1 with no wrap.
  - OVL and LOAD do not clear cnt. Only RST does.
- OVL may change in any cycle. It is sampled in the same cycle as hit.

## Timing
- Y is combinational from E, EN, LOAD and registered state. It has zero latency: Y is asserted in the cycle the final pattern bit is presented.
- No match is possible until N-1 samples have been consumed after reset, LOAD, or a non-overlapping match.
- CNT is registered. It reflects a match one cycle after Y.
- Reset values: Y=0 (fill=0 while RST is applied), CNT=0.
- Reset mid-sequence: partial history is discarded, and the next match needs N new bits.
- LOAD together with a would-be match: LOAD wins, Y=0, and cnt is unchanged.

## Configuration
- SEQDET_COUNT_EN defined:
  - cnt register and saturating increment are implemented as described.
- SEQDET_COUNT_EN undefined:
  - No counter logic.
  - CNT is tied to 0 and the port width is unchanged.
  - Y behaviour is identical.

## Test plan
- Reset, default pattern 1101, OVL=0, EN=1, E stream 1,1,0,1 -> Y=1 only in the 4th cycle; CNT=1 on the next cycle.
- OVL=1, pattern 4'b1010, stream 1,0,1,0,1,0 -> Y=1 in cycles 4 and 6; CNT=2. Same stream with OVL=0 -> Y=1 in cycle 4 only; CNT=1.
- Stream 1,1,0 with EN=0 gaps of 3 cycles between bits, then 1 -> Y=1 only at the final EN=1 cycle; Y=0 in every gap cycle.
- LOAD with PAT=4'b0110 after bits 1,1 of 1101 are fed; then stream 1,0,1,1,0 -> no match on the old pattern; Y=1 on the final 0; a LOAD cycle with EN=1 never asserts Y.
- RST asserted after bits 1,1,0; then single bit 1 -> Y=0; the full 1,1,0,1 afterwards -> Y=1.
- CW=2, 5 non-overlapping 1101 matches -> CNT reads 1,2,3,3,3 (saturates). Without SEQDET_COUNT_EN -> CNT=0 throughout and Y is unchanged.

Source files
------------

// File: rtl/seq_detector_param_if.sv
// Serial-stream bus for seq_detector_param: data/strobe/pattern inputs, match and count outputs.
// The testbench or upstream logic drives through the master modport.
interface seq_detector_param_if #(
  parameter int N  = 4,
  parameter int CW = 8
);
  logic          E;
  logic          EN;
  logic          LOAD;
  logic [N-1:0]  PAT;
  logic          OVL;
  logic          Y;
  logic [CW-1:0] CNT;

  modport master (output E, EN, LOAD, PAT, OVL, input Y, CNT);
  modport slave  (input E, EN, LOAD, PAT, OVL, output Y, CNT);
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial sequence detector with in-band pattern load and overlap select.
// Define SEQDET_COUNT_EN to build the saturating match counter; otherwise CNT is tied to zero.
module seq_detector_param #(
  parameter int           N           = 4,
  parameter logic [N-1:0] DEFAULT_PAT = N'(4'b1101),
  parameter int           CW          = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  seq_detector_param_if.slave  bus
);

  localparam int            FW       = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);

  logic [N-1:0]  pat_q,  pat_d;
  logic [N-2:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [N-1:0]  window_s;
  logic          hit_s;

  assign window_s = {hist_q, bus.E};
  assign hit_s    = bus.EN & ~bus.LOAD & (fill_q == FILL_MAX) & (window_s == pat_q);
  assign bus.Y    = hit_s;

  // Next-state for pattern, history and fill; LOAD discards the current sample.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    if (bus.LOAD) begin
      pat_d  = bus.PAT;
      hist_d = '0;
      fill_d = '0;
    end else if (bus.EN) begin
      if (hit_s && !bus.OVL) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window_s[N-2:0];
        if (fill_q == FILL_MAX) begin
          fill_d = fill_q;
        end else begin
          fill_d = fill_q + FW'(1);
        end
      end
    end else begin
      hist_d = hist_q;
    end
  end

  // Detector state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q  <= DEFAULT_PAT;
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQDET_COUNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating match count; only reset clears it.
  always_comb begin
    if (hit_s && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.CNT = cnt_q;
`else
  assign bus.CNT = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param (N=4); a second CW=2 instance checks saturation.
module tb_seq_detector_param;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cnt8_m;
  int   cnt2_m;

  typedef struct {
    logic       rst;
    logic       e;
    logic       en;
    logic       ld;
    logic [3:0] pat;
    logic       ovl;
    logic       ey;
  } vec_t;

  vec_t vecs[$];

  seq_detector_param_if #(.N(4), .CW(8)) bus8 ();
  seq_detector_param_if #(.N(4), .CW(2)) bus2 ();

  seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1101), .CW(8)) dut (
    .CLK(clk), .RST(rst), .bus(bus8.slave)
  );
  seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1101), .CW(2)) dut2 (
    .CLK(clk), .RST(rst), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void add(input logic r, input logic e, input logic en, input logic ld,
                              input logic [3:0] p, input logic o, input logic ey);
    vec_t v;
    v.rst = r; v.e = e; v.en = en; v.ld = ld; v.pat = p; v.ovl = o; v.ey = ey;
    vecs.push_back(v);
  endfunction

  task automatic step(input vec_t v, input string nm);
    int exp8;
    int exp2;
    @(negedge clk);
    rst = v.rst;
    bus8.E = v.e; bus8.EN = v.en; bus8.LOAD = v.ld; bus8.PAT = v.pat; bus8.OVL = v.ovl;
    bus2.E = v.e; bus2.EN = v.en; bus2.LOAD = v.ld; bus2.PAT = v.pat; bus2.OVL = v.ovl;
    #1;
`ifdef SEQDET_COUNT_EN
    exp8 = cnt8_m;
    exp2 = cnt2_m;
`else
    exp8 = 0;
    exp2 = 0;
`endif
    chk({nm, " Y"}, 32'(bus8.Y), 32'(v.ey));
    chk({nm, " Y2"}, 32'(bus2.Y), 32'(v.ey));
    chk({nm, " CNT"}, 32'(bus8.CNT), 32'(exp8));
    chk({nm, " CNT2"}, 32'(bus2.CNT), 32'(exp2));
    @(posedge clk);
    if (v.rst) begin
      cnt8_m = 0;
      cnt2_m = 0;
    end else if (v.ey) begin
      if (cnt8_m < 255) cnt8_m++;
      if (cnt2_m < 3) cnt2_m++;
    end
  endtask

  initial begin
    vec_t v;
    checks = 0; errors = 0; cnt8_m = 0; cnt2_m = 0;
    rst = 1'b1;
    // reset: EN held low so Y is defined before state initialises
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    // default 1101, non-overlapping
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    // pattern 1010 overlapping: hits at bits 4 and 6
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, ~i[0], 1'b1, 1'b0, 4'b0000, 1'b1, (i == 3) || (i == 5));
    // same stream non-overlapping: hit at bit 4 only
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b0, ~i[0], 1'b1, 1'b0, 4'b0000, 1'b0, i == 3);
    // 1101 with EN gaps; gap E values would otherwise match
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    run_table("tbl");

    // LOAD coinciding with a would-be match on 1101: LOAD wins
    vecs.delete();
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    run_table("load");

    // reset mid-sequence discards history and restores 1101
    vecs.delete();
    add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1);
    run_table("rst");

    // five non-overlapping 1101 matches: CW=2 instance saturates at 3
    for (int m = 0; m < 5; m++) begin
      v.rst = 1'b0; v.en = 1'b1; v.ld = 1'b0; v.pat = 4'b0000; v.ovl = 1'b0;
      v.e = 1'b1; v.ey = 1'b0; step(v, "sat b0");
      v.e = 1'b1; v.ey = 1'b0; step(v, "sat b1");
      v.e = 1'b0; v.ey = 1'b0; step(v, "sat b2");
      v.e = 1'b1; v.ey = 1'b1; step(v, "sat b3");
    end
    v.rst = 1'b0; v.e = 1'b0; v.en = 1'b0; v.ld = 1'b0; v.pat = 4'b0000; v.ovl = 1'b0; v.ey = 1'b0;
    step(v, "sat end");
`ifdef SEQDET_COUNT_EN
    chk("sat CNT2 final", 32'(bus2.CNT), 32'd3);
`else
    chk("sat CNT2 final", 32'(bus2.CNT), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic run_table(input string nm);
    foreach (vecs[i]) step(vecs[i], $sformatf("%s[%0d]", nm, i));
  endtask

endmodule
